// File: rtl/scarv_ram_initiator.sv
// SoC req/gnt + recv/ack bus to single-port BRAM bridge with address decode,
// error responses and a 2-entry in-order response FIFO. Optional macro: SCARV_RAM_INITIATOR_PERF_EN.
module scarv_ram_initiator #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter logic [31:0] SIZE      = 32'h0000_4000,
  parameter int unsigned RAM_AW    = 14,
  parameter int unsigned WIDTH     = 32,
  parameter bit          WRITE_EN  = 1'b1
) (
  input  logic                 g_clk,
  input  logic                 g_reset,
  input  logic                 mem_req,
  output logic                 mem_gnt,
  input  logic                 mem_wen,
  input  logic [WIDTH/8-1:0]   mem_strb,
  input  logic [WIDTH-1:0]     mem_wdata,
  input  logic [31:0]          mem_addr,
  output logic                 mem_recv,
  input  logic                 mem_ack,
  output logic                 mem_error,
  output logic [WIDTH-1:0]     mem_rdata,
  output logic                 ram_cen,
  output logic                 ram_wen,
  output logic [WIDTH/8-1:0]   ram_strb,
  output logic [WIDTH-1:0]     ram_wdata,
  output logic [RAM_AW-1:0]    ram_addr,
  input  logic [WIDTH-1:0]     ram_rdata
`ifdef SCARV_RAM_INITIATOR_PERF_EN
  ,
  output logic [31:0]          perf_rd,
  output logic [31:0]          perf_wr,
  output logic [31:0]          perf_err
`endif
);

  localparam int unsigned DEPTH = 2;

  logic                hit;
  logic                bad;
  logic                pop;
  logic                push;
  logic [2:0]          occupancy;
  logic                push_err;
  logic [WIDTH-1:0]    push_data;

  logic                inflight;
  logic                inf_bad;
  logic                inf_wen;
  logic [1:0]          count;
  logic                wr_ptr;
  logic                rd_ptr;
  logic [DEPTH-1:0]    fifo_err;
  logic [WIDTH-1:0]    fifo_data [DEPTH];

  // Address decode and access legality.
  assign hit = ((mem_addr & ~(SIZE - 32'd1)) == BASE_ADDR);
  assign bad = !hit || (mem_wen && !WRITE_EN);

  // Occupancy counts responses already owed: queued plus the one in flight.
  assign pop       = mem_recv && mem_ack;
  assign occupancy = 3'(count) + 3'(inflight) - 3'(pop);
  assign mem_gnt   = mem_req && !g_reset && (occupancy < 3'(DEPTH));

  assign ram_cen   = mem_gnt && !bad;
  assign ram_wen   = mem_wen;
  assign ram_strb  = mem_strb;
  assign ram_wdata = mem_wdata;
  assign ram_addr  = mem_addr[RAM_AW-1:0];

  // RAM read data is captured into the FIFO the cycle after the grant.
  assign push      = inflight;
  assign push_err  = inf_bad;
  assign push_data = (inf_bad || inf_wen) ? '0 : ram_rdata;

  assign mem_recv  = (count != 2'd0);
  assign mem_error = mem_recv && fifo_err[rd_ptr];
  assign mem_rdata = mem_recv ? fifo_data[rd_ptr] : '0;

  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      inflight <= 1'b0;
      inf_bad  <= 1'b0;
      inf_wen  <= 1'b0;
      count    <= 2'd0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      fifo_err <= '0;
      for (int i = 0; i < int'(DEPTH); i++) fifo_data[i] <= '0;
    end else begin
      inflight <= mem_gnt;
      inf_bad  <= bad;
      inf_wen  <= mem_wen;
      if (push) begin
        fifo_data[wr_ptr] <= push_data;
        fifo_err[wr_ptr]  <= push_err;
        wr_ptr            <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + 2'(push) - 2'(pop);
    end
  end

`ifdef SCARV_RAM_INITIATOR_PERF_EN
  // Saturating event counters, one increment per granted request.
  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      perf_rd  <= '0;
      perf_wr  <= '0;
      perf_err <= '0;
    end else if (mem_gnt) begin
      if (bad) begin
        if (perf_err != 32'hFFFF_FFFF) perf_err <= perf_err + 32'd1;
      end else if (mem_wen) begin
        if (perf_wr != 32'hFFFF_FFFF) perf_wr <= perf_wr + 32'd1;
      end else begin
        if (perf_rd != 32'hFFFF_FFFF) perf_rd <= perf_rd + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_scarv_ram_initiator.sv
// Directed bench for scarv_ram_initiator: vector table of single transactions
// plus streaming, back-pressure and mid-operation reset sequences.
module tb_scarv_ram_initiator;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req;
  logic        wen;
  logic [3:0]  strb;
  logic [31:0] wdata;
  logic [31:0] addr;
  logic        ack;
  logic        load;

  logic        gnt, recv, err;
  logic [31:0] rdata;
  logic        ram_cen, ram_wen;
  logic [3:0]  ram_strb;
  logic [31:0] ram_wdata;
  logic [13:0] ram_addr;
  logic [31:0] ram_rdata;

  logic        ro_gnt, ro_recv, ro_err;
  logic [31:0] ro_rdata;
  logic        ro_cen, ro_wen;
  logic [3:0]  ro_strb;
  logic [31:0] ro_wdata;
  logic [13:0] ro_addr;

`ifdef SCARV_RAM_INITIATOR_PERF_EN
  logic [31:0] perf_rd, perf_wr, perf_err;
  logic [31:0] ro_perf_rd, ro_perf_wr, ro_perf_err;
`endif

  scarv_ram_initiator dut (
    .g_clk(clk), .g_reset(rst),
    .mem_req(req), .mem_gnt(gnt), .mem_wen(wen), .mem_strb(strb),
    .mem_wdata(wdata), .mem_addr(addr), .mem_recv(recv), .mem_ack(ack),
    .mem_error(err), .mem_rdata(rdata),
    .ram_cen(ram_cen), .ram_wen(ram_wen), .ram_strb(ram_strb),
    .ram_wdata(ram_wdata), .ram_addr(ram_addr), .ram_rdata(ram_rdata)
`ifdef SCARV_RAM_INITIATOR_PERF_EN
    , .perf_rd(perf_rd), .perf_wr(perf_wr), .perf_err(perf_err)
`endif
  );

  scarv_ram_initiator #(.WRITE_EN(1'b0)) dut_ro (
    .g_clk(clk), .g_reset(rst),
    .mem_req(req), .mem_gnt(ro_gnt), .mem_wen(wen), .mem_strb(strb),
    .mem_wdata(wdata), .mem_addr(addr), .mem_recv(ro_recv), .mem_ack(ack),
    .mem_error(ro_err), .mem_rdata(ro_rdata),
    .ram_cen(ro_cen), .ram_wen(ro_wen), .ram_strb(ro_strb),
    .ram_wdata(ro_wdata), .ram_addr(ro_addr), .ram_rdata(ram_rdata)
`ifdef SCARV_RAM_INITIATOR_PERF_EN
    , .perf_rd(ro_perf_rd), .perf_wr(ro_perf_wr), .perf_err(ro_perf_err)
`endif
  );

  // Behavioural BRAM: 1-cycle read latency, byte strobes, test preloads.
  logic [31:0] ram [4096];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4096; i++) ram[i] <= '0;
      ram[4]    <= 32'hDEADBEEF;
      ram_rdata <= '0;
    end else if (load) begin
      for (int i = 0; i < 8; i++) ram[i] <= 32'h1000_0000 + 32'(i);
    end else if (ram_cen) begin
      if (ram_wen) begin
        for (int b = 0; b < 4; b++)
          if (ram_strb[b]) ram[ram_addr[13:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
      end else begin
        ram_rdata <= ram[ram_addr[13:2]];
      end
    end
  end

  int n_vec  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        wen;
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [31:0] wdata;
    logic        exp_cen;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [11];

  // One transaction with mem_ack high: checks drive, latency and response.
  task automatic do_txn(input vec_t v);
    int   t;
    logic ro_exp_err;
    @(posedge clk); #1;
    req = 1'b1; wen = v.wen; addr = v.addr; strb = v.strb; wdata = v.wdata; ack = 1'b1;
    @(negedge clk);
    t = 0;
    while (!gnt && t < 10) begin @(negedge clk); t++; end
    if (!gnt) begin
      check("gnt_timeout", 32'(gnt), 32'd1);
      req = 1'b0;
      return;
    end
    ro_exp_err = v.exp_err || v.wen;
    check("ram_cen", 32'(ram_cen), 32'(v.exp_cen));
    check("ram_addr", 32'(ram_addr), 32'(v.addr[13:0]));
    check("ro_ram_cen", 32'(ro_cen), 32'(v.exp_cen && !v.wen));
    @(posedge clk); #1;
    req = 1'b0;
    @(negedge clk);
    check("recv_early", 32'(recv), 32'd0);
    @(negedge clk);
    check("recv", 32'(recv), 32'd1);
    check("error", 32'(err), 32'(v.exp_err));
    check("rdata", rdata, v.exp_rdata);
    check("ro_error", 32'(ro_err), 32'(ro_exp_err));
    check("ro_rdata", ro_rdata, ro_exp_err ? 32'd0 : v.exp_rdata);
  endtask

  // Streams n reads of preloaded words 0..n-1; mem_ack held low until ack_from.
  task automatic stream(input int n, input int ack_from);
    int g = 0;
    int r = 0;
    @(posedge clk); #1; load = 1'b1;
    @(posedge clk); #1; load = 1'b0;
    for (int cyc = 0; cyc < 30 && r < n; cyc++) begin
      req = (g < n); wen = 1'b0; strb = '0; wdata = '0;
      addr = 32'(g * 4);
      ack = (cyc >= ack_from);
      @(negedge clk);
      if (ack_from == 0 && req) check("b2b_gnt", 32'(gnt), 32'd1);
      if (gnt) g++;
      if (ack_from > 0 && cyc == ack_from - 1) begin
        check("bp_grants", 32'(g), 32'd2);
        check("bp_gnt_low", 32'(gnt), 32'd0);
      end
      if (recv) begin
        check("stream_rdata", rdata, 32'h1000_0000 + 32'(r));
        check("stream_error", 32'(err), 32'd0);
        if (ack_from == 0 && r == 0) check("first_resp_cycle", 32'(cyc), 32'd2);
        if (ack) r++;
      end
      @(posedge clk); #1;
    end
    req = 1'b0;
    check("stream_grants", 32'(g), 32'(n));
    check("stream_resps", 32'(r), 32'(n));
  endtask

  initial begin
    vecs[0]  = '{1'b0, 32'h0000_0010, 4'h0, 32'h0,          1'b1, 1'b0, 32'hDEADBEEF};
    vecs[1]  = '{1'b0, 32'h0000_4000, 4'h0, 32'h0,          1'b0, 1'b1, 32'h0};
    vecs[2]  = '{1'b1, 32'h0000_0008, 4'h2, 32'h0000_AB00,  1'b1, 1'b0, 32'h0};
    vecs[3]  = '{1'b0, 32'h0000_0008, 4'h0, 32'h0,          1'b1, 1'b0, 32'h0000_AB00};
    vecs[4]  = '{1'b1, 32'h0000_0000, 4'hF, 32'h1234_5678,  1'b1, 1'b0, 32'h0};
    vecs[5]  = '{1'b0, 32'h0000_0000, 4'h0, 32'h0,          1'b1, 1'b0, 32'h1234_5678};
    vecs[6]  = '{1'b1, 32'h0000_0004, 4'h9, 32'hAABB_CCDD,  1'b1, 1'b0, 32'h0};
    vecs[7]  = '{1'b0, 32'h0000_0004, 4'h0, 32'h0,          1'b1, 1'b0, 32'hAA00_00DD};
    vecs[8]  = '{1'b0, 32'hFFFF_FFFC, 4'h0, 32'h0,          1'b0, 1'b1, 32'h0};
    vecs[9]  = '{1'b0, 32'h0000_3FFC, 4'h0, 32'h0,          1'b1, 1'b0, 32'h0};
    vecs[10] = '{1'b1, 32'h0000_4004, 4'hF, 32'h1,          1'b0, 1'b1, 32'h0};

    rst = 1'b1; req = 1'b1; wen = 1'b0; strb = '0; wdata = '0; addr = '0;
    ack = 1'b0; load = 1'b0;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_cen", 32'(ram_cen), 32'd0);
    check("rst_recv", 32'(recv), 32'd0);
    check("rst_error", 32'(err), 32'd0);
    check("rst_rdata", rdata, 32'd0);
`ifdef SCARV_RAM_INITIATOR_PERF_EN
    check("rst_perf_rd", perf_rd, 32'd0);
`endif
    @(posedge clk); #1;
    rst = 1'b0; req = 1'b0;

    for (int i = 0; i < 11; i++) do_txn(vecs[i]);

    stream(8, 0);
    stream(4, 6);

    // Reset with one read in flight and one response queued.
    @(posedge clk); #1;
    req = 1'b1; wen = 1'b0; addr = 32'h0; ack = 1'b0;
    @(negedge clk);
    check("rs_gnt0", 32'(gnt), 32'd1);
    @(posedge clk); #1;
    addr = 32'h4;
    @(negedge clk);
    check("rs_gnt1", 32'(gnt), 32'd0 + 32'd1);
    @(posedge clk); #1;
    rst = 1'b1; addr = 32'h8;
    @(negedge clk);
    check("rs_gnt_forced", 32'(gnt), 32'd0);
    check("rs_cen_forced", 32'(ram_cen), 32'd0);
    check("rs_recv_before", 32'(recv), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0; req = 1'b0; ack = 1'b1;
    @(negedge clk);
    check("rs_recv_after", 32'(recv), 32'd0);
`ifdef SCARV_RAM_INITIATOR_PERF_EN
    check("rs_perf_rd", perf_rd, 32'd0);
    check("rs_perf_wr", perf_wr, 32'd0);
    check("rs_perf_err", perf_err, 32'd0);
`endif
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("rs_no_stale", 32'(recv), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/scarv_ram_initiator.md
Name: scarv_ram_initiator

Overview:
- Initiator-side bridge from the SoC request/response memory bus (req/gnt, recv/ack) to a single port of the on-chip BRAM (cen/wen/strb/wdata/addr/rdata).
- The RAM port has a fixed 1-cycle read latency and no back-pressure. This block adds address decode and error generation.
- Responses are returned in order through a 2-entry response FIFO, so a stalled ack never loses RAM read data.

Parameters:
- BASE_ADDR, 32'h0000_0000: byte base address of the RAM window. Must be aligned to SIZE.
- SIZE, 32'h0000_4000: window size in bytes. Must be a power of 2.
- RAM_AW, 14: RAM port byte-address width. Equals log2(SIZE).
- WIDTH, 32: data width. Strobe width is WIDTH/8.
- WRITE_EN, 1: 0 makes the window read-only; writes then return an error.

Ports:
- g_clk  in  1  clock.
- g_reset  in  1  synchronous, active-high reset.
- mem_req  in  1  request valid.
- mem_gnt  out  1  request accepted this cycle.
- mem_wen  in  1  1 = write, 0 = read.
- mem_strb  in  WIDTH/8  write byte strobes.
- mem_wdata  in  WIDTH  write data.
- mem_addr  in  32  byte address.
- mem_recv  out  1  response valid.
- mem_ack  in  1  response accepted.
- mem_error  out  1  response is an error.
- mem_rdata  out  WIDTH  response read data.
- ram_cen  out  1  RAM access strobe.
- ram_wen  out  1  RAM write enable.
- ram_strb  out  WIDTH/8  RAM byte strobes.
- ram_wdata  out  WIDTH  RAM write data.
- ram_addr  out  RAM_AW  RAM byte address; bits [1:0] are passed through.
- ram_rdata  in  WIDTH  RAM read data, valid the cycle after ram_cen.

Behaviour:
- Reset values: mem_gnt=0, mem_recv=0, mem_error=0, mem_rdata=0, ram_cen=0. FIFO count=0, inflight=0.
- Decode: hit = ((mem_addr & ~(SIZE-1)) == BASE_ADDR). bad = !hit || (mem_wen && !WRITE_EN).
- Grant: mem_gnt = mem_req && !g_reset && (count + inflight - pop) < 2, where pop = mem_recv && mem_ack. mem_gnt depends combinationally on mem_ack.
- RAM drive: ram_cen = mem_gnt && !bad. ram_wen/strb/wdata/addr pass through mem_wen/strb/wdata/addr[RAM_AW-1:0] combinationally.
- Tracking: inflight flop is set the cycle after any grant. It records bad and wen for the granted request.
- Cycle after grant: one entry {error, rdata} is pushed into the FIFO.
  - Good read: rdata = ram_rdata, error = 0.
  - Good write: rdata = 0, error = 0.
  - Bad access: rdata = 0, error = 1.
  - A bad access never asserts ram_cen.
- Response side:
  - mem_recv = FIFO not empty. mem_error/mem_rdata come from the FIFO head and are registered (no ram_rdata combinational path).
  - Minimum latency from grant to mem_recv is 2 cycles.
  - While mem_recv=1 and mem_ack=0, the head entry holds stable.
  - Push and pop in the same cycle are both legal; count is unchanged.
- Throughput: with mem_ack tied high, one grant per cycle is sustained. With mem_ack low, at most 2 unacknowledged responses exist; mem_gnt then drops.
- Ordering: responses are returned strictly in grant order.
- Reset mid-operation: g_reset=1 at any edge clears the FIFO and inflight. An in-flight read is discarded. mem_gnt and ram_cen are forced low while g_reset is high.

Optional Feature:
- Macro: SCARV_RAM_INITIATOR_PERF_EN.
- When defined, three output ports are added, each 32 bits:
  - perf_rd: counts granted good reads.
  - perf_wr: counts granted good writes.
  - perf_err: counts granted bad accesses.
- Counters reset to 0, increment on grant and saturate at 32'hFFFF_FFFF.
- When undefined, the ports and logic are absent; core behaviour is identical.

Test Plan:
- Single read, RAM word 0x10 = 32'hDEADBEEF, mem_ack=1:
  - Grant cycle 0: ram_cen=1, ram_addr=0x10.
  - Cycle 2: mem_recv=1, mem_rdata=32'hDEADBEEF, mem_error=0.
- Back-to-back: 8 reads of 0x0..0x1C, mem_req and mem_ack held high.
  - 8 consecutive gnt cycles.
  - 8 consecutive in-order responses starting 2 cycles after the first grant.
- Back-pressure: mem_ack=0, 4 reads issued.
  - Exactly 2 grants, then mem_gnt=0.
  - mem_rdata stable.
  - Raising mem_ack drains both responses, then the remaining 2 reads are granted.
- Error: read of 0x0000_4000 with default parameters.
  - ram_cen stays 0.
  - Response mem_error=1, mem_rdata=0.
  - With WRITE_EN=0, a write to 0x4 returns mem_error=1 and ram_cen stays 0.
- Byte write: write 0x8, strb=4'b0010, wdata=32'h0000AB00, then read 0x8 from prior 0.
  - Read returns 32'h0000AB00.
  - Write response returns mem_rdata=0.
- Reset: assert g_reset for 1 cycle while a read is inflight and 1 entry is queued.
  - Next cycle mem_recv=0.
  - No stale response appears afterwards.
  - With PERF_EN defined, counters read 0.
